// File: rtl/reverb_pkg.sv
// Shared types, constants and helpers for the procedural reverb impulse-response generator.
package reverb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GEN,
    WAIT_DONE,
    DONE
  } gen_state_t;

  localparam logic [15:0] C_LFSR_MASK         = 16'hB400;
  localparam logic [15:0] C_LFSR_DEFAULT_SEED = 16'hACE1;
  localparam int          C_GAIN_DECIMAL_BITS = 15;

  function automatic int n_taps(input int stages_log2, input int depth_log2);
    return 1 << (stages_log2 + depth_log2);
  endfunction

  // One step of the right-shifting Galois LFSR; the mask is applied when bit 0 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ C_LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit Galois LFSR noise source with synchronous load and single-step advance.
module lfsr16_galois
  import reverb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] state
);

  // An all-zero state would lock the LFSR, so a zero seed falls back to the default.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= C_LFSR_DEFAULT_SEED;
    end else if (load) begin
      state <= (seed == 16'h0000) ? C_LFSR_DEFAULT_SEED : seed;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/reverb_ir_generator.sv
// Streams a full FIR tap set of LFSR noise shaped by an exponentially decaying envelope,
// then waits for the FIR to acknowledge the load.
module reverb_ir_generator
  import reverb_pkg::*;
#(
  parameter int G_NUM_STAGES_LOG2  = 2,
  parameter int G_STAGE_DEPTH_LOG2 = 2,
  parameter int G_TAP_WIDTH        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic [15:0]            lfsr_seed,
  input  logic [15:0]            init_amplitude,
  input  logic [15:0]            decay_gain,
  output logic [G_TAP_WIDTH-1:0] tap_dout,
  output logic                   tap_dout_valid,
  input  logic                   tap_dout_ready,
  input  logic                   tap_load_done,
  output logic                   busy,
  output logic                   done
);

  localparam int                N_TAPS      = n_taps(G_NUM_STAGES_LOG2, G_STAGE_DEPTH_LOG2);
  localparam int                CNT_W       = G_NUM_STAGES_LOG2 + G_STAGE_DEPTH_LOG2;
  localparam logic [CNT_W-1:0]  LAST_IDX    = CNT_W'(N_TAPS - 1);
  localparam int                EXTRA_SHIFT = 16 - G_TAP_WIDTH;
  localparam int                TAP_MAX_I   = (1 << (G_TAP_WIDTH - 1)) - 1;
  localparam logic signed [32:0] TAP_MAX    = 33'(TAP_MAX_I);
  localparam logic signed [32:0] TAP_MIN    = 33'(-TAP_MAX_I - 1);

  gen_state_t       state;
  gen_state_t       state_next;
  logic [15:0]      env;
  logic [15:0]      decay;
  logic [15:0]      env_next;
  logic [31:0]      env_prod;
  logic [16:0]      env_shift;
  logic [15:0]      lfsr_state;
  logic [15:0]      lfsr_next;
  logic [15:0]      seed_eff;
  logic [CNT_W-1:0] tap_cnt;
  logic             soft_reset;
  logic             handshake;
  logic             last_tap;

  // Noise (signed) times envelope (unsigned 1.15), rescaled to the tap width and clamped.
  function automatic logic [G_TAP_WIDTH-1:0] tap_calc(input logic [15:0] noise,
                                                      input logic [15:0] amp);
    logic signed [32:0]     prod;
    logic signed [32:0]     scaled;
    logic [G_TAP_WIDTH-1:0] result;
    prod   = $signed({{17{noise[15]}}, noise}) * $signed({17'b0, amp});
    scaled = (prod >>> C_GAIN_DECIMAL_BITS) >>> EXTRA_SHIFT;
    if (scaled > TAP_MAX) begin
      result = TAP_MAX[G_TAP_WIDTH-1:0];
    end else if (scaled < TAP_MIN) begin
      result = TAP_MIN[G_TAP_WIDTH-1:0];
    end else begin
      result = scaled[G_TAP_WIDTH-1:0];
    end
    return result;
  endfunction

  assign soft_reset = reset | ~enable;
  assign handshake  = (state == GEN) & tap_dout_ready;
  assign last_tap   = (tap_cnt == LAST_IDX);
  assign seed_eff   = (lfsr_seed == 16'h0000) ? C_LFSR_DEFAULT_SEED : lfsr_seed;
  assign lfsr_next  = lfsr_step(lfsr_state);

  // Gains of 1.0 or more can push the envelope past 16 bits, so it clamps at full scale.
  assign env_prod  = env * decay;
  assign env_shift = 17'(env_prod >> C_GAIN_DECIMAL_BITS);
  assign env_next  = env_shift[16] ? 16'hFFFF : env_shift[15:0];

  lfsr16_galois u_lfsr (
    .clk     (clk),
    .reset   (soft_reset),
    .load    (state == LOAD),
    .seed    (lfsr_seed),
    .advance (handshake),
    .state   (lfsr_state)
  );

  always_ff @(posedge clk) begin
    if (soft_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = LOAD;
      LOAD:      state_next = GEN;
      GEN:       if (handshake && last_tap) state_next = WAIT_DONE;
      WAIT_DONE: if (tap_load_done) state_next = DONE;
      DONE:      if (start) state_next = LOAD;
      default:   state_next = IDLE;
    endcase
  end

  // The tap register always holds the tap for the current index; the next one is
  // computed from the post-update LFSR and envelope so taps stream at one per clock.
  always_ff @(posedge clk) begin
    if (soft_reset) begin
      tap_dout <= '0;
      env      <= '0;
      decay    <= '0;
      tap_cnt  <= '0;
    end else begin
      case (state)
        LOAD: begin
          env      <= init_amplitude;
          decay    <= decay_gain;
          tap_cnt  <= '0;
          tap_dout <= tap_calc(seed_eff, init_amplitude);
        end
        GEN: begin
          if (handshake) begin
            tap_cnt  <= tap_cnt + 1'b1;
            env      <= env_next;
            tap_dout <= tap_calc(lfsr_next, env_next);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign tap_dout_valid = (state == GEN);
  assign busy           = (state == LOAD) | (state == GEN) | (state == WAIT_DONE);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_reverb_ir_generator.sv
// Scoreboard bench: a plain-arithmetic reference model queues expected taps, a negedge monitor checks them.
module tb_reverb_ir_generator;

  localparam int N_TAPS = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [15:0] lfsr_seed;
  logic [15:0] init_amplitude;
  logic [15:0] decay_gain;
  logic [15:0] tap_dout;
  logic        tap_dout_valid;
  logic        tap_dout_ready;
  logic        tap_load_done;
  logic        busy;
  logic        done;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          hs_count     = 0;
  int          duty         = 100;
  logic [15:0] exp_q[$];
  bit          stalled      = 1'b0;
  logic [15:0] held_tap     = '0;

  reverb_ir_generator #(
    .G_NUM_STAGES_LOG2  (2),
    .G_STAGE_DEPTH_LOG2 (2),
    .G_TAP_WIDTH        (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .start          (start),
    .lfsr_seed      (lfsr_seed),
    .init_amplitude (init_amplitude),
    .decay_gain     (decay_gain),
    .tap_dout       (tap_dout),
    .tap_dout_valid (tap_dout_valid),
    .tap_dout_ready (tap_dout_ready),
    .tap_load_done  (tap_load_done),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model: straight from the arithmetic rules, 16 taps per set.
  function automatic void build_expected(input logic [15:0] seed, input logic [15:0] amp,
                                         input logic [15:0] dec);
    longint s;
    longint e;
    longint noise;
    longint t;
    logic [15:0] tap;
    s = (seed == 16'h0000) ? 64'hACE1 : longint'(seed);
    e = longint'(amp);
    for (int k = 0; k < N_TAPS; k++) begin
      noise = (s >= 32768) ? s - 65536 : s;
      t = (noise * e) >>> 15;
      if (t > 32767) t = 32767;
      if (t < -32768) t = -32768;
      tap = t[15:0];
      exp_q.push_back(tap);
      s = (s % 2 == 1) ? ((s / 2) ^ 64'hB400) : (s / 2);
      e = (e * longint'(dec)) / 32768;
      if (e > 65535) e = 65535;
    end
  endfunction

  // Ready is refreshed just after each edge, after stimulus has had its chance to change duty.
  initial begin
    tap_dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tap_dout_ready = ($urandom_range(99) < duty);
    end
  end

  always @(negedge clk) begin
    if (tap_dout_valid) begin
      if (stalled) check_output("stall_hold", {16'h0, tap_dout}, {16'h0, held_tap});
      if (tap_dout_ready) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_tap: got %h, expected no tap", tap_dout);
        end else begin
          check_output($sformatf("tap%0d", hs_count), {16'h0, tap_dout}, {16'h0, exp_q.pop_front()});
        end
        hs_count++;
        stalled = 1'b0;
      end else begin
        stalled  = 1'b1;
        held_tap = tap_dout;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic apply_stimulus(input logic [15:0] seed, input logic [15:0] amp, input logic [15:0] dec);
    lfsr_seed      = seed;
    init_amplitude = amp;
    decay_gain     = dec;
    build_expected(seed, amp, dec);
    hs_count = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("load_valid", {31'h0, tap_dout_valid}, 32'h0);
    check_output("load_busy", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    check_output("first_valid", {31'h0, tap_dout_valid}, 32'h1);
  endtask

  task automatic wait_handshakes(input int target, input string name);
    int guard;
    guard = 0;
    while (hs_count < target && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (hs_count < target) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s_timeout: got %0d handshakes, expected %0d", name, hs_count, target);
    end
  endtask

  task automatic inject_gen_events();
    wait_handshakes(4, "inject");
    start         = 1'b1;
    tap_load_done = 1'b1;
    @(posedge clk); #1;
    start         = 1'b0;
    tap_load_done = 1'b0;
    check_output("gen_ignore_busy", {31'h0, busy}, 32'h1);
    check_output("gen_ignore_done", {31'h0, done}, 32'h0);
    check_output("gen_ignore_valid", {31'h0, tap_dout_valid}, 32'h1);
  endtask

  task automatic finish_set();
    wait_handshakes(N_TAPS, "taps");
    @(posedge clk); #1;
    check_output("wait_valid", {31'h0, tap_dout_valid}, 32'h0);
    check_output("wait_busy", {31'h0, busy}, 32'h1);
    check_output("wait_done", {31'h0, done}, 32'h0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("wait_start_ignored", {30'h0, busy, done}, 32'h2);
    tap_load_done = 1'b1;
    @(posedge clk); #1;
    tap_load_done = 1'b0;
    check_output("done_flag", {30'h0, busy, done}, 32'h1);
    @(posedge clk); #1;
    check_output("done_held", {31'h0, done}, 32'h1);
    check_output("queue_drained", exp_q.size(), 32'h0);
  endtask

  task automatic run_set(input logic [15:0] seed, input logic [15:0] amp, input logic [15:0] dec,
                         input int d, input bit inject);
    duty = d;
    apply_stimulus(seed, amp, dec);
    if (inject) inject_gen_events();
    finish_set();
  endtask

  task automatic abort_run(input bit use_enable);
    duty = 100;
    apply_stimulus(16'h1D2C, 16'h7FFF, 16'h7000);
    wait_handshakes(6, "abort");
    if (use_enable) enable = 1'b0;
    else reset = 1'b1;
    duty = 0;
    @(posedge clk); #1;
    check_output(use_enable ? "enable_low_outputs" : "reset_outputs",
                 {13'h0, tap_dout_valid, busy, done, tap_dout}, 32'h0);
    exp_q.delete();
    reset  = 1'b0;
    enable = 1'b1;
    @(posedge clk); #1;
    check_output("idle_after_abort", {30'h0, busy, tap_dout_valid}, 32'h0);
    run_set(16'h1D2C, 16'h7FFF, 16'h7000, 100, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    start          = 1'b0;
    tap_load_done  = 1'b0;
    lfsr_seed      = '0;
    init_amplitude = '0;
    decay_gain     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_state", {13'h0, tap_dout_valid, busy, done, tap_dout}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_output("idle_state", {30'h0, busy, done}, 32'h0);

    run_set(16'h0001, 16'h8000, 16'h8000, 100, 1'b0);
    run_set(16'hACE1, 16'h7FFF, 16'h4000, 100, 1'b0);
    run_set(16'hACE1, 16'h7FFF, 16'h4000, 30,  1'b1);
    run_set(16'h0000, 16'h7FFF, 16'h4000, 100, 1'b0);
    run_set(16'h1234, 16'h0000, 16'h8000, 30,  1'b0);
    run_set(16'hBEEF, 16'hFFFF, 16'h0000, 100, 1'b1);
    run_set(16'h5A5A, 16'h9000, 16'hFFFF, 30,  1'b0);
    run_set(16'hACE1, 16'h7FFF, 16'h4000, 100, 1'b0);
    abort_run(1'b0);
    abort_run(1'b1);
    for (int i = 0; i < 4; i++) begin
      run_set(16'($urandom_range(65535)), 16'($urandom_range(65535)),
              16'($urandom_range(65535)), $urandom_range(30, 100), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/reverb_ir_generator.md
Name: reverb_ir_generator

Overview:
Procedural impulse-response generator that sits directly upstream of the reverb FIR tap-load port. It produces the full tap set as an AXI-stream-style tap stream: LFSR white noise shaped by an exponentially decaying envelope. It then waits for the downstream FIR to report that tap loading is complete. Software programs seed, amplitude and decay, pulses start, and gets a reverb IR without writing every tap.

Parameters:
G_NUM_STAGES_LOG2, 2, must match the downstream FIR; the tap count is 2**(G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2).
G_STAGE_DEPTH_LOG2, 2, must match the downstream FIR.
G_TAP_WIDTH, 16, width of the signed output tap (8..16).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  block enable; low acts as a synchronous soft reset
start  in  1  single-cycle request to generate a new tap set
lfsr_seed  in  16  noise seed; a value of 0 is replaced by 16'hACE1
init_amplitude  in  16  starting envelope, 1.15 unsigned
decay_gain  in  16  per-tap envelope multiplier, 1.15 unsigned
tap_dout  out  G_TAP_WIDTH  signed tap value
tap_dout_valid  out  1  tap valid
tap_dout_ready  in  1  downstream FIR ready
tap_load_done  in  1  FIR tap_din_done indication
busy  out  1  high in LOAD, GEN and WAIT_DONE
done  out  1  high in DONE

Behaviour:
- Reset values: on reset=1 or enable=0, all outputs are 0 and the FSM is in IDLE. This takes effect mid-operation with no completion of the current tap; a partially loaded FIR must be reloaded by a new start.
- States: IDLE, LOAD, GEN, WAIT_DONE, DONE.
- IDLE: start=1 moves to LOAD.
- LOAD (1 cycle): latch seed (0 is replaced by 16'hACE1), env <= init_amplitude, decay <= decay_gain, tap_cnt <= 0; then move to GEN. First tap_dout_valid appears 2 cycles after the start cycle.
- GEN: tap_dout_valid=1.
  - tap_dout is registered and held stable while valid=1 and ready=0.
  - On each valid&ready cycle: tap_cnt++, the LFSR advances one step, env <= (env*decay)>>15 (truncate, then saturate to 16'hFFFF), and the next tap is registered in the same cycle. This gives back-to-back taps at 1 per clock while ready stays high.
  - After the handshake of tap N_TAPS-1: valid drops in the next cycle and the FSM moves to WAIT_DONE.
- LFSR: 16-bit Galois, right-shift, feedback mask 16'hB400. The noise sample is the current state reinterpreted as signed 16-bit.
- Tap arithmetic:
  - prod = signed(noise) * signed({1'b0,env}) gives 33 bits signed; compute prod_rs = prod >>> 15.
  - Right-shift by an additional (16-G_TAP_WIDTH) bits.
  - Saturate to [-2**(G_TAP_WIDTH-1), 2**(G_TAP_WIDTH-1)-1].
  - The tap for index k uses the env and LFSR state as they stand before the k-th update.
- WAIT_DONE: wait for tap_load_done=1, then move to DONE. If tap_load_done is already 1 on entry, the move takes 1 cycle.
- DONE: done=1 and is held. start=1 moves to LOAD (regeneration).
- start outside IDLE/DONE is ignored.
- tap_load_done is ignored outside WAIT_DONE.
- decay_gain=0: taps after index 0 are all 0.
- init_amplitude=0: all taps are 0, but the full count is still emitted.
- decay_gain >= 16'h8000: treated as a gain of 1.0 or more, with env saturating at 16'hFFFF.

Decomposition:
- Shared package reverb_pkg:
  - gen_state_t enum (IDLE, LOAD, GEN, WAIT_DONE, DONE)
  - C_LFSR_MASK = 16'hB400
  - C_LFSR_DEFAULT_SEED = 16'hACE1
  - C_GAIN_DECIMAL_BITS = 15
  - function n_taps(stages_log2, depth_log2)
- One natural sub-module: lfsr16_galois, with ports clk, reset, load, seed, advance, state.
- The FSM, envelope multiplier and saturation stay in the top module.

Test Plan:
- Basic run (defaults, 16 taps): seed=16'h0001, amp=16'h8000, decay=16'h8000, ready=1 always.
  - Expect 16 back-to-back taps, first tap 2 cycles after start.
  - Each tap equals the signed LFSR state times 1.0, saturated; the first tap is 16'h0001.
  - After the last tap, valid drops and busy stays high until tap_load_done, then done=1.
- Decay: seed=16'hACE1, amp=16'h7FFF, decay=16'h4000 (0.5).
  - env sequence is 7FFF, 3FFF, 1FFF, ...
  - Each tap matches the model (noise*env)>>>15 bit-exactly against a C/Python reference.
- Backpressure: random tap_dout_ready at 30% duty.
  - tap_dout stays stable while stalled.
  - Exactly 16 handshakes occur, and the tap sequence is identical to the ready=1 run.
- Zero seed and zero amplitude: seed=0 gives the same output as seed=16'hACE1; amp=0 gives 16 zero taps followed by done.
- Reset and enable mid-GEN: assert reset after tap 5.
  - Next cycle: valid=0, busy=0, done=0, FSM in IDLE.
  - A new start reproduces the sequence from tap 0.
  - Repeat the same check with enable=0.
- Ignored and early events:
  - start pulsed during GEN and WAIT_DONE has no effect.
  - tap_load_done pulsed during GEN is ignored.
  - start in DONE regenerates an identical set.
